// File: rtl/traffic_disp_pkg.sv
// Shared definitions for the traffic countdown display.
//   - 7-segment patterns (active-high, bit order {g,f,e,d,c,b,a})
//   - light_led bit positions for the two lamp triplets
//   - serial BCD converter state encoding
//   - seg_of(): BCD nibble to segment pattern
package traffic_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int L1_R = 5;
  localparam int L1_Y = 4;
  localparam int L1_G = 3;
  localparam int L2_R = 2;
  localparam int L2_Y = 1;
  localparam int L2_G = 0;

  typedef enum logic [1:0] {
    CONV_LOAD  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_WRITE = 2'd2
  } conv_state_e;

  // Nibbles above 9 never come out of the converter; they decode to blank.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_disp_bin2bcd_seq.sv
// Serial double-dabble converter: binary count (clamped to 99) -> 2-digit BCD.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           request a conversion of bin_i
//   bin_i [CNT_W]     raw binary count
//   busy_o            conversion in progress
//   done_o            one-cycle pulse, bcd_o/zero_o valid
//   bcd_o [8]         {tens, units} BCD result
//   zero_o            raw count captured as zero
//   state_o           converter state (debug)
// Handshake: start_i is sampled only in LOAD while busy_o is low; the value of
// bin_i on that cycle is captured. busy_o stays high through SHIFT and WRITE;
// done_o pulses for exactly one cycle (WRITE) with bcd_o and zero_o valid.
module bin2bcd_seq
  import traffic_disp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       bcd_o,
  output logic             zero_o,
  output conv_state_e      state_o
);

  conv_state_e state_q, state_d;
  logic [15:0] sr_q, sr_d;     // {tens, units, binary}
  logic [2:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic [7:0]  clamped;
  logic [7:0]  adj;

  assign clamped = (bin_i > CNT_W'(99)) ? 8'd99 : 8'(bin_i);

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    adj = sr_q[15:8];
    if (sr_q[15:12] >= 4'd5) adj[7:4] = sr_q[15:12] + 4'd3;
    if (sr_q[11:8]  >= 4'd5) adj[3:0] = sr_q[11:8]  + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    done_o  = 1'b0;
    busy_o  = (state_q != CONV_LOAD);
    case (state_q)
      CONV_LOAD: begin
        if (start_i) begin
          sr_d    = {8'h00, clamped};
          zero_d  = (bin_i == '0);
          cnt_d   = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        sr_d  = {adj, sr_q[7:0]} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = CONV_WRITE;
      end
      CONV_WRITE: begin
        done_o  = 1'b1;
        state_d = CONV_LOAD;
      end
      default: state_d = CONV_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CONV_LOAD;
      sr_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign bcd_o   = sr_q[15:8];
  assign zero_o  = zero_q;
  assign state_o = state_q;

endmodule

// File: rtl/traffic_disp.sv
// 4-digit multiplexed 7-segment countdown display for two traffic lights.
// Ports:
//   clk_fst            fast system clock
//   rst                synchronous active-low reset
//   g1_cnt, g2_cnt     remaining counts of light 1 / light 2 (binary)
//   light_led [6]      lamps {L1 R,Y,G, L2 R,Y,G}; only the Y lamps are shown
//   seg [7]            segments {g,f,e,d,c,b,a}, active-high
//   dp                 decimal point, lit on a units digit while that Y lamp is on
//   dig_sel [4]        active-low digit enable: L1 tens, L1 units, L2 tens, L2 units
module traffic_disp
  import traffic_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             clk_fst,
  input  logic             rst,
  input  logic [CNT_W-1:0] g1_cnt,
  input  logic [CNT_W-1:0] g2_cnt,
  input  logic [5:0]       light_led,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       dig_sel
);

  localparam int PW = $clog2(SCAN_DIV);

  logic             chan_q, chan_d;
  logic [7:0]       bcd1_q, bcd1_d, bcd2_q, bcd2_d;
  logic             blank1_q, blank1_d, blank2_q, blank2_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       dig_sel_q, dig_sel_d;

  logic [CNT_W-1:0] conv_bin;
  logic             conv_busy, conv_done, conv_zero;
  logic [7:0]       conv_bcd;
  conv_state_e      conv_dbg_state;

  logic [7:0]       pair_bcd;
  logic             pair_blank;
  logic [3:0]       nib;

  // Red/green lamps and the converter state are not displayed.
  logic unused_ok;
  assign unused_ok = ^{light_led[L1_R], light_led[L1_G], light_led[L2_R],
                       light_led[L2_G], conv_dbg_state};

  assign conv_bin = chan_q ? g2_cnt : g1_cnt;

  bin2bcd_seq #(.CNT_W(CNT_W)) u_conv (
    .clk     (clk_fst),
    .rst_n   (rst),
    .start_i (~conv_busy),
    .bin_i   (conv_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .zero_o  (conv_zero),
    .state_o (conv_dbg_state)
  );

  always_comb begin
    chan_d   = chan_q;
    bcd1_d   = bcd1_q;
    bcd2_d   = bcd2_q;
    blank1_d = blank1_q;
    blank2_d = blank2_q;
    if (conv_done) begin
      if (!chan_q) begin
        bcd1_d   = conv_bcd;
        blank1_d = conv_zero;
      end else begin
        bcd2_d   = conv_bcd;
        blank2_d = conv_zero;
      end
      chan_d = ~chan_q;
    end

    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end

    // Decode from next-state values so a WRITE landing on an advance is
    // shown immediately. idx bit1 picks the light, bit0 picks units.
    pair_bcd   = idx_d[1] ? bcd2_d : bcd1_d;
    pair_blank = idx_d[1] ? blank2_d : blank1_d;
    nib        = idx_d[0] ? pair_bcd[3:0] : pair_bcd[7:4];
    seg_d      = seg_of(nib);
    if (pair_blank || (!idx_d[0] && (pair_bcd[7:4] == 4'd0))) seg_d = SEG_BLANK;
    dp_d       = idx_d[0] && (idx_d[1] ? light_led[L2_Y] : light_led[L1_Y]);
    dig_sel_d  = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk_fst) begin
    if (!rst) begin
      chan_q    <= 1'b0;
      bcd1_q    <= 8'h00;
      bcd2_q    <= 8'h00;
      blank1_q  <= 1'b1;
      blank2_q  <= 1'b1;
      presc_q   <= '0;
      idx_q     <= 2'd0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b0;
      dig_sel_q <= 4'b1110;
    end else begin
      chan_q    <= chan_d;
      bcd1_q    <= bcd1_d;
      bcd2_q    <= bcd2_d;
      blank1_q  <= blank1_d;
      blank2_q  <= blank2_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_traffic_disp.sv
module tb_traffic_disp;
  import traffic_disp_pkg::*;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] g1_cnt, g2_cnt;
  logic [5:0] light_led;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig_sel;

  int n_checks = 0;
  int n_pass   = 0;

  const logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  traffic_disp #(.SCAN_DIV(SD), .CNT_W(8)) dut (
    .clk_fst   (clk),
    .rst       (rst),
    .g1_cnt    (g1_cnt),
    .g2_cnt    (g2_cnt),
    .light_led (light_led),
    .seg       (seg),
    .dp        (dp),
    .dig_sel   (dig_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int idx_of(input logic [3:0] ds);
    case (ds)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Expected segments for display position idx given the two counts.
  function automatic logic [6:0] model_seg(input int idx, input int c1, input int c2);
    int c, v;
    if (idx < 0) return 7'h00;
    c = (idx < 2) ? c1 : c2;
    if (c == 0) return 7'h00;
    v = (c > 99) ? 99 : c;
    if (idx % 2 == 0) return (v / 10 == 0) ? 7'h00 : PAT[v / 10];
    return PAT[v % 10];
  endfunction

  function automatic logic model_dp(input int idx, input logic [5:0] leds);
    if (idx == 1) return leds[4];
    if (idx == 3) return leds[1];
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int a, input int b, input logic [5:0] l);
    @(negedge clk);
    g1_cnt    = 8'(a);
    g2_cnt    = 8'(b);
    light_led = l;
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int ei;
    @(negedge clk);
    rst = 1'b0; g1_cnt = 0; g2_cnt = 0; light_led = 6'b010_010;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 4'b1110)
      $display("FAIL reset_vals seg=%h dp=%b dig_sel=%b, want 00 0 1110", seg, dp, dig_sel);
    else n_pass++;
    rst = 1'b1;
    // after posedge k of release, index = ((k+1)/SD)%4; two full scans, all blank
    for (int k = 0; k < 2 * 4 * SD; k++) begin
      @(negedge clk);
      ei = ((k + 1) / SD) % 4;
      n_checks++;
      if (dig_sel !== ~(4'b0001 << ei) || seg !== 7'h00)
        $display("FAIL reset_scan k=%0d dig_sel=%b seg=%h, want dig_sel=%b seg=00",
                 k, dig_sel, seg, ~(4'b0001 << ei));
      else n_pass++;
    end
  endtask

  task automatic test_conversion();
    int ei;
    @(negedge clk);
    rst = 1'b0; g1_cnt = 20; g2_cnt = 7; light_led = 6'b000_000;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (dut.bcd1_q !== 8'h20 || dut.bcd2_q !== 8'h07)
      $display("FAIL conv_bcd bcd1=%h bcd2=%h, want 20 07", dut.bcd1_q, dut.bcd2_q);
    else n_pass++;
    for (int k = 0; k < 4 * SD; k++) begin
      @(negedge clk);
      ei = idx_of(dig_sel);
      n_checks++;
      if (ei < 0 || seg !== model_seg(ei, 20, 7) || dp !== 1'b0)
        $display("FAIL conv_scan dig_sel=%b seg=%h dp=%b, want seg=%h dp=0",
                 dig_sel, seg, dp, model_seg(ei, 20, 7));
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    int ei;
    drive(200, 42, 6'b000_000);
    settle();
    for (int k = 0; k < 4 * SD; k++) begin
      @(negedge clk);
      ei = idx_of(dig_sel);
      n_checks++;
      if (ei < 0 || seg !== model_seg(ei, 200, 42) || (ei < 2 && seg !== 7'h6F))
        $display("FAIL clamp dig_sel=%b seg=%h, want %h", dig_sel, seg, model_seg(ei, 200, 42));
      else n_pass++;
    end
  endtask

  task automatic test_yellow_dp();
    int ei;
    drive(3, 15, 6'b010_100);
    settle();
    for (int k = 0; k < 4 * SD; k++) begin
      @(negedge clk);
      ei = idx_of(dig_sel);
      n_checks++;
      if (ei < 0 || dp !== (dig_sel == 4'b1101) || seg !== model_seg(ei, 3, 15))
        $display("FAIL yellow_dp dig_sel=%b dp=%b seg=%h, want dp=%b seg=%h",
                 dig_sel, dp, seg, (dig_sel == 4'b1101), model_seg(ei, 3, 15));
      else n_pass++;
    end
  endtask

  task automatic test_countdown();
    int ei;
    int steps [3] = '{10, 9, 0};
    for (int s = 0; s < 3; s++) begin
      drive(33, steps[s], 6'b000_010);
      settle();
      for (int k = 0; k < 4 * SD; k++) begin
        @(negedge clk);
        ei = idx_of(dig_sel);
        n_checks++;
        if (ei < 0 || seg !== model_seg(ei, 33, steps[s]) || dp !== model_dp(ei, 6'b000_010))
          $display("FAIL countdown g2=%0d dig_sel=%b seg=%h dp=%b, want seg=%h dp=%b",
                   steps[s], dig_sel, seg, dp, model_seg(ei, 33, steps[s]),
                   model_dp(ei, 6'b000_010));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int ei, a, b;
    logic [5:0] l;
    for (int t = 0; t < 20; t++) begin
      a = 0; b = 0;
      case ($urandom_range(0, 3))
        0: a = 0;
        1: a = $urandom_range(1, 99);
        2: a = $urandom_range(100, 255);
        default: a = $urandom_range(1, 9);
      endcase
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 99);
        2: b = $urandom_range(100, 255);
        default: b = $urandom_range(1, 9);
      endcase
      l = 6'($urandom_range(0, 63));
      drive(a, b, l);
      settle();
      for (int k = 0; k < 4 * SD; k++) begin
        @(negedge clk);
        ei = idx_of(dig_sel);
        n_checks++;
        if (ei < 0 || seg !== model_seg(ei, a, b) || dp !== model_dp(ei, l))
          $display("FAIL random g1=%0d g2=%0d led=%b dig_sel=%b seg=%h dp=%b, want seg=%h dp=%b",
                   a, b, l, dig_sel, seg, dp, model_seg(ei, a, b), model_dp(ei, l));
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic found;
    int ei;
    @(negedge clk);
    rst = 1'b0; g1_cnt = 5; g2_cnt = 55; light_led = 6'b000_000;
    @(negedge clk);
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = (dut.chan_q == 1'b1) && (dut.conv_dbg_state == CONV_SHIFT);
    end
    n_checks++;
    if (!found) $display("FAIL midrst_wait channel 1 SHIFT not reached within 40 cycles");
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (dut.bcd2_q !== 8'h00 || dut.blank2_q !== 1'b1 || dut.chan_q !== 1'b0 ||
        dut.conv_dbg_state !== CONV_LOAD)
      $display("FAIL midrst_state bcd2=%h blank2=%b chan=%b st=%0d, want 00 1 0 LOAD",
               dut.bcd2_q, dut.blank2_q, dut.chan_q, dut.conv_dbg_state);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dut.conv_dbg_state !== CONV_SHIFT)
      $display("FAIL midrst_restart st=%0d, want SHIFT", dut.conv_dbg_state);
    else n_pass++;
    repeat (9) @(negedge clk);
    n_checks++;
    if (dut.bcd1_q !== 8'h05 || dut.bcd2_q !== 8'h00)
      $display("FAIL midrst_ch0 bcd1=%h bcd2=%h, want 05 00", dut.bcd1_q, dut.bcd2_q);
    else n_pass++;
    settle();
    for (int k = 0; k < 4 * SD; k++) begin
      @(negedge clk);
      ei = idx_of(dig_sel);
      n_checks++;
      if (ei < 0 || seg !== model_seg(ei, 5, 55))
        $display("FAIL midrst_scan dig_sel=%b seg=%h, want %h", dig_sel, seg, model_seg(ei, 5, 55));
      else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0; g1_cnt = 0; g2_cnt = 0; light_led = 0;
    test_reset();
    test_conversion();
    test_clamp();
    test_yellow_dp();
    test_countdown();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
